// File: rtl/tour_sequencer.sv
// tour_sequencer: walks a solved knight's tour, splits each one-hot move into a
// vertical leg (OP_MOVE) and a horizontal leg (OP_FANFARE), and issues each leg
// over a valid/ready command channel. After each accepted leg it waits for a
// completion pulse before moving on.
module tour_sequencer #(
    parameter int         NUM_MOVES  = 24,
    parameter logic [3:0] OP_MOVE    = 4'h2,
    parameter logic [3:0] OP_FANFARE = 4'h3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  move,
    output logic [4:0]  indx,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    input  logic        resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;
    localparam logic [4:0] LAST   = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERT, S_VWAIT, S_HORZ, S_HWAIT
    } state_t;

    state_t      state, state_n;
    logic [4:0]  indx_n;
    logic [15:0] cmd_n;
    logic        vld_n, done_n, err_n;
    logic [7:0]  mv_q, mv_n;

    // Vertical leg: bits 0,3 dy=+1; 1,2 dy=+2; 4,7 dy=-1; 5,6 dy=-2.
    function automatic logic [15:0] vert_leg(input logic [7:0] m);
        logic [15:0] c;
        if (|(m & 8'b0000_1001))      c = {OP_MOVE, HEAD_N, 4'd1};
        else if (|(m & 8'b0000_0110)) c = {OP_MOVE, HEAD_N, 4'd2};
        else if (|(m & 8'b1001_0000)) c = {OP_MOVE, HEAD_S, 4'd1};
        else                          c = {OP_MOVE, HEAD_S, 4'd2};
        return c;
    endfunction

    // Horizontal leg: bits 0,7 dx=+2; 1,6 dx=+1; 2,5 dx=-1; 3,4 dx=-2.
    function automatic logic [15:0] horz_leg(input logic [7:0] m);
        logic [15:0] c;
        if (|(m & 8'b1000_0001))      c = {OP_FANFARE, HEAD_E, 4'd2};
        else if (|(m & 8'b0100_0010)) c = {OP_FANFARE, HEAD_E, 4'd1};
        else if (|(m & 8'b0010_0100)) c = {OP_FANFARE, HEAD_W, 4'd1};
        else                          c = {OP_FANFARE, HEAD_W, 4'd2};
        return c;
    endfunction

    logic move_onehot;
    assign move_onehot = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);

    assign busy = (state != S_IDLE);

    // Next-state and next-output logic; cmd/cmd_vld are computed one cycle ahead
    // so they leave the block straight from flops.
    always_comb begin
        state_n = state;
        indx_n  = indx;
        cmd_n   = cmd;
        vld_n   = cmd_vld;
        done_n  = 1'b0;
        err_n   = err;
        mv_n    = mv_q;
        case (state)
            S_IDLE: if (start) begin
                state_n = S_LOAD;
                indx_n  = 5'd0;
                err_n   = 1'b0;
            end
            S_LOAD: begin
                mv_n = move;
                if (!move_onehot) begin
                    err_n   = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cmd_n   = vert_leg(move);
                    vld_n   = 1'b1;
                    state_n = S_VERT;
                end
            end
            S_VERT: if (cmd_rdy) begin
                vld_n   = 1'b0;
                state_n = S_VWAIT;
            end
            S_VWAIT: if (resp_rdy) begin
                cmd_n   = horz_leg(mv_q);
                vld_n   = 1'b1;
                state_n = S_HORZ;
            end
            S_HORZ: if (cmd_rdy) begin
                vld_n   = 1'b0;
                state_n = S_HWAIT;
            end
            S_HWAIT: if (resp_rdy) begin
                if (indx == LAST) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    indx_n  = indx + 5'd1;
                    state_n = S_LOAD;
                end
            end
            default: begin
                vld_n   = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            indx    <= 5'd0;
            cmd     <= 16'h0000;
            cmd_vld <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mv_q    <= 8'h00;
        end else begin
            state   <= state_n;
            indx    <= indx_n;
            cmd     <= cmd_n;
            cmd_vld <= vld_n;
            done    <= done_n;
            err     <= err_n;
            mv_q    <= mv_n;
        end
    end

endmodule
